// File: rtl/fetch_if.sv
// Fetch stage bus bundle: redirect port, instruction-memory req/ack bus and
// the valid/ready instruction handshake towards decode.
//   master : the fetch stage (drives imem request and decode outputs)
//   slave  : the environment (memory, decode, redirect source)
interface fetch_if;
  localparam int unsigned XW = 32;

  logic          redirect_i;
  logic [XW-1:0] redirect_pc_i;
  logic          imem_req_o;
  logic [XW-1:0] imem_addr_o;
  logic          imem_ack_i;
  logic [XW-1:0] imem_data_i;
  logic [XW-1:0] ir_o;
  logic [XW-1:0] pc_o;
  logic [XW-1:0] pc_plus4_o;
  logic          valid_o;
  logic          ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_ack_i, imem_data_i, ready_i,
    output imem_req_o, imem_addr_o, ir_o, pc_o, pc_plus4_o, valid_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_ack_i, imem_data_i, ready_i,
    input  imem_req_o, imem_addr_o, ir_o, pc_o, pc_plus4_o, valid_o
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage.
// Holds the PC, issues word reads over a req/ack bus and presents the fetched
// word with its PC to decode over valid/ready. A redirect reloads the PC and
// discards any in-flight or held instruction.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : fetch_if.master (redirect, imem req/addr/ack/data,
//            ir/pc/pc_plus4/valid/ready)
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  fetch_if.master  bus
);
  localparam int unsigned XW = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e        state_q;
  logic [XW-1:0] pc_q;
  logic [XW-1:0] addr_q;
  logic [XW-1:0] ir_q;
  logic [XW-1:0] pco_q;
  logic [XW-1:0] pc4_q;
  logic          valid_q;
  logic          req_q;

  logic [XW-1:0] tgt_c;
  logic [XW-1:0] addr_inc_c;

  // Redirect target forced word-aligned; increment wraps naturally at 32 bits.
  assign tgt_c      = bus.redirect_pc_i & ~XW'(3);
  assign addr_inc_c = addr_q + XW'(4);

  // Control and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      pco_q   <= '0;
      pc4_q   <= XW'(4);
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= FETCH;
          addr_q  <= pc_q;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack_i && !bus.redirect_i) begin
            ir_q    <= bus.imem_data_i;
            pco_q   <= addr_q;
            pc4_q   <= addr_inc_c;
            pc_q    <= addr_inc_c;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end else if (bus.imem_ack_i) begin
            // Acked word belongs to the old path; refetch at target next cycle.
            pc_q   <= tgt_c;
            addr_q <= tgt_c;
          end else if (bus.redirect_i) begin
            // Request must stay stable until acked; drain it first.
            pc_q    <= tgt_c;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.redirect_i) begin
            pc_q <= tgt_c;
          end
          if (bus.imem_ack_i) begin
            addr_q  <= bus.redirect_i ? tgt_c : pc_q;
            state_q <= FETCH;
          end
        end
        HOLD: begin
          if (bus.redirect_i) begin
            valid_q <= 1'b0;
            pc_q    <= tgt_c;
            addr_q  <= tgt_c;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end else if (bus.ready_i) begin
            valid_q <= 1'b0;
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = addr_q;
  assign bus.ir_o        = ir_q;
  assign bus.pc_o        = pco_q;
  assign bus.pc_plus4_o  = pc4_q;
  assign bus.valid_o     = valid_q;
endmodule
